texture_port_arbiter: RTL and testbench
=======================================

// Module: texture_port_arbiter
// PURPOSE
//  Shares the single read port of the 5x5 character texture ROM (sync read, registered data_out)
//  between N_REQ pixel requesters (player sprite, enemy sprites, HUD icon renderer).
//  Round-robin arbitration with bounded burst ownership.
//  Routes each returned texel back to its requester with a per-requester valid strobe.
//  Sits between the OLED pixel renderers and character_textures; the texture module is unmodified.
// PARAMETERS
//  N_REQ      3  number of requesters (2..8)
//  ADDR_W     5  texel address width (25 texels used)
//  DATA_W     4  texel data width
//  ROM_LAT    1  ROM read latency in clk edges, addr registered -> data_out valid (1..4)
//  MAX_BURST  4  consecutive grants an owner may take while another requester waits (1..15)
// PORTS
//  clk       in   1               system clock (same clk as texture ROM)
//  rst_n     in   1               asynchronous active-low reset
//  req       in   N_REQ           req[i]: requester i wants one texel; held until gnt[i]
//  addr_in   in   N_REQ*ADDR_W    requester i address in bits [i*ADDR_W +: ADDR_W]
//  gnt       out  N_REQ           one-hot/zero, combinational; addr_in[i] consumed at this edge
//  rd_valid  out  N_REQ           one-hot/zero, registered; rd_data belongs to requester i
//  rd_data   out  DATA_W          texel, equals rom_data while any rd_valid high
//  rom_addr  out  ADDR_W          registered address to texture ROM addr
//  rom_data  in   DATA_W          texture ROM data_out
//  busy      out  1               state==OWN or any read in flight
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, owner=0, rr_ptr=0, burst_cnt=0, rom_addr=0,
//   in-flight pipe cleared; gnt=0, rd_valid=0, busy=0. rd_data is combinational rom_data, forced 0 when no rd_valid.
//  Reset mid-read discards in-flight texels: no rd_valid after rst_n deasserts.
//  FSM: IDLE: no owner. If any req: winner = first set req scanning from rr_ptr upward (wrap).
//    gnt[winner]=1, owner<=winner, burst_cnt<=1, -> OWN.
//  OWN, req[owner]=1:
//   - burst_cnt<MAX_BURST, or no other req: grant owner.
//     burst_cnt<=min(burst_cnt+1, MAX_BURST) (saturates, never wraps).
//   - burst_cnt==MAX_BURST and other req pending: grant first other req scanning from owner+1.
//     owner<=it, burst_cnt<=1, rr_ptr<=it+1.
//  OWN, req[owner]=0: other req -> same-cycle grant to first scanning from owner+1 (no bubble),
//   owner/burst_cnt/rr_ptr updated as above; none -> no grant, rr_ptr<=owner+1, -> IDLE.
//  Exactly one grant per cycle whenever any req is high (work-conserving); never two.
//  On grant edge: rom_addr<=addr_in[winner]; pipe stage0<={1,winner}.
//  Pipe is 1+ROM_LAT stages deep; shifts every clk.
//  Latency: gnt in cycle C -> rd_valid[i] high exactly in cycle C+1+ROM_LAT, one cycle per grant.
//  Throughput: 1 texel/cycle; back-to-back grants give back-to-back rd_valid in grant order.
//  Requester dropping req before gnt: allowed, nothing issued. addr_in is sampled only on grant.
//  rr_ptr wraps N_REQ-1 -> 0; indices modulo N_REQ.
//  busy=0 only in IDLE with empty pipe.
//  The ROM anim_clk/dir update may change texels between reads; not hidden by this block.
// TESTING
//  T1 reset: rst_n=0 mid-burst with reads in flight -> all outputs 0.
//   No rd_valid for 1+ROM_LAT cycles after release.
//  T2 single requester: req[1]=1, addr 12, held -> gnt[1] every cycle.
//   rd_valid[1] from cycle 2, rd_data=4'b1111; burst_cnt saturates at 4 and never hands over.
//  T3 contention: req=3'b111 continuously from IDLE -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0...
//  T4 early release: req[0] drops after 2 grants while req[2]=1 -> gnt[2] in next cycle, no idle gap.
//  T5 routing: req0 addr 2, req1 addr 12, interleaved -> rd_valid[0] rd_data=4'b1000;
//   rd_valid[1] rd_data=4'b1111, order preserved.
//  T6 ROM_LAT=3: single grant in cycle C -> rd_valid in cycle C+4 only. Random req stress:
//   check <=1 gnt per cycle, no starvation beyond (N_REQ-1)*MAX_BURST cycles,
//   rd_valid count == gnt count.

Source files
------------

// File: rtl/texture_port_arbiter.sv
// -----------------------------------------------------------------------------
// texture_port_arbiter
//
// Shares the single synchronous read port of the character texture ROM between
// N_REQ pixel requesters (player sprite, enemy sprites, HUD icon renderer).
//
// Arbitration is round-robin with bounded burst ownership: the current owner
// may keep the port for consecutive grants, but once it has taken MAX_BURST
// grants while someone else is waiting, the port moves on to the next
// requester after it. Losing req hands the port over in the same cycle, so
// the port never idles while any req is high.
//
// Each grant launches a one-hot tag down a 1+ROM_LAT stage pipe that runs in
// step with the ROM. When the tag falls out of the pipe, the ROM data_out
// belongs to that requester, and rd_valid tells it so.
//
// Ports
//   clk       system clock, shared with the texture ROM
//   rst_n     asynchronous active-low reset
//   req       req[i]: requester i wants one texel; held until gnt[i]
//   addr_in   requester i address in bits [i*ADDR_W +: ADDR_W]
//   gnt       one-hot/zero, combinational; addr_in[i] is consumed at this edge
//   rd_valid  one-hot/zero, registered; rd_data belongs to requester i
//   rd_data   texel; rom_data while any rd_valid is high, otherwise 0
//   rom_addr  registered address to the texture ROM
//   rom_data  texture ROM data_out
//   busy      port owned or a read still in flight
// -----------------------------------------------------------------------------
module texture_port_arbiter #(
  parameter int N_REQ     = 3,  // number of requesters (2..8)
  parameter int ADDR_W    = 5,  // texel address width
  parameter int DATA_W    = 4,  // texel data width
  parameter int ROM_LAT   = 1,  // ROM read latency, rom_addr -> rom_data (1..4)
  parameter int MAX_BURST = 4   // grants an owner may take while others wait (1..15)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int DEPTH   = 1 + ROM_LAT;   // tag pipe: address register + ROM latency
  localparam int BURST_W = 4;             // holds MAX_BURST up to 15

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  // Result of a round-robin scan: whether anything was found and where.
  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Next requester index, wrapping N_REQ-1 -> 0 (N_REQ need not be a power of 2).
  function automatic idx_t idx_inc(input idx_t i);
    return (i == idx_t'(N_REQ - 1)) ? '0 : i + idx_t'(1);
  endfunction

  // First set bit of v, scanning upward from start and wrapping around.
  function automatic pick_t pick_first(input logic [N_REQ-1:0] v, input idx_t start);
    pick_t p;
    idx_t  i;
    p = '0;
    i = start;
    for (int k = 0; k < N_REQ; k++) begin
      if (!p.found && v[i]) begin
        p.found = 1'b1;
        p.idx   = i;
      end
      i = idx_inc(i);
    end
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                        state;
  idx_t                          owner;
  idx_t                          rr_ptr;
  logic [BURST_W-1:0]            burst_cnt;
  // pipe[0] is the newest grant; pipe[DEPTH-1] lines up with rom_data.
  logic [DEPTH-1:0][N_REQ-1:0]   pipe;

  // ---------------------------------------------------------------------------
  // Grant decision and next-state logic
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0]   others;
  pick_t              from_ptr;
  pick_t              from_next;
  logic               grant_any;
  idx_t               grant_idx;
  logic [N_REQ-1:0]   grant_vec;
  logic [ADDR_W-1:0]  addr_sel;
  state_t             state_nx;
  idx_t               owner_nx;
  idx_t               rr_ptr_nx;
  logic [BURST_W-1:0] burst_nx;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would infer a latch.
    others    = req & ~(N_REQ'(1) << owner);
    from_ptr  = pick_first(req, rr_ptr);
    from_next = pick_first(others, idx_inc(owner));
    grant_any = 1'b0;
    grant_idx = '0;
    state_nx  = state;
    owner_nx  = owner;
    rr_ptr_nx = rr_ptr;
    burst_nx  = burst_cnt;

    case (state)
      IDLE: begin
        if (from_ptr.found) begin
          grant_any = 1'b1;
          grant_idx = from_ptr.idx;
          owner_nx  = from_ptr.idx;
          burst_nx  = BURST_W'(1);
          state_nx  = OWN;
        end
      end

      OWN: begin
        if (req[owner] && ((burst_cnt < BURST_MAX) || !from_next.found)) begin
          // Owner keeps the port; the count saturates so a lone owner never
          // wraps back into a fresh burst.
          grant_any = 1'b1;
          grant_idx = owner;
          if (burst_cnt < BURST_MAX) begin
            burst_nx = burst_cnt + BURST_W'(1);
          end
        end else if (from_next.found) begin
          // Burst used up with someone waiting, or owner let go: hand over in
          // the same cycle so there is no bubble.
          grant_any = 1'b1;
          grant_idx = from_next.idx;
          owner_nx  = from_next.idx;
          burst_nx  = BURST_W'(1);
          rr_ptr_nx = idx_inc(from_next.idx);
        end else begin
          rr_ptr_nx = idx_inc(owner);
          state_nx  = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // One-hot grant and the winner's address, as plain muxes.
  always_comb begin
    grant_vec = '0;
    addr_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_any && (grant_idx == idx_t'(i))) begin
        grant_vec[i] = 1'b1;
        addr_sel     = addr_in[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rom_addr  <= '0;
      // NOTE: the tag pipe carries valid bits, so it must be cleared on reset;
      // otherwise texels read before reset would surface afterwards.
      pipe      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the values from before this edge.
      state     <= state_nx;
      owner     <= owner_nx;
      rr_ptr    <= rr_ptr_nx;
      burst_cnt <= burst_nx;
      if (grant_any) begin
        rom_addr <= addr_sel;
      end
      pipe      <= {pipe[DEPTH-2:0], grant_vec};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // gnt is held low during reset so nothing is consumed while the block is held.
  assign gnt      = rst_n ? grant_vec : '0;
  assign rd_valid = pipe[DEPTH-1];
  assign rd_data  = (|rd_valid) ? rom_data : '0;
  assign busy     = (state == OWN) || (|pipe);

endmodule

// File: tb/tb_texture_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_texture_port_arbiter
//
// Two arbiters share one stimulus: dut_a with ROM_LAT=1, dut_b with ROM_LAT=3,
// each in front of its own ROM model. A per-cycle reference model decides who
// should win from the arbitration rules and keeps a history of grants; the
// expected read returns are that history delayed by 1+ROM_LAT cycles.
// Directed phases cover reset, single requester, contention, early release,
// routing and latency; a randomized phase stresses the handshake.
// -----------------------------------------------------------------------------
module tb_texture_port_arbiter;

  localparam int N          = 3;
  localparam int AW         = 5;
  localparam int DW         = 4;
  localparam int MB         = 4;
  localparam int LA         = 1;
  localparam int LB         = 3;
  localparam int MAXC       = 4096;
  localparam int STARVE_MAX = (N - 1) * MB;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr_in;

  logic [N-1:0]    gnt_a, gnt_b, rv_a, rv_b;
  logic [DW-1:0]   rd_a, rd_b;
  logic [AW-1:0]   ra_a, ra_b;
  logic [DW-1:0]   rom_a, rom_b0, rom_b1, rom_b2;
  logic            busy_a, busy_b;

  always #5 clk = ~clk;

  texture_port_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LA), .MAX_BURST(MB)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_in(addr_in),
    .gnt(gnt_a), .rd_valid(rv_a), .rd_data(rd_a), .rom_addr(ra_a),
    .rom_data(rom_a), .busy(busy_a)
  );

  texture_port_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LB), .MAX_BURST(MB)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_in(addr_in),
    .gnt(gnt_b), .rd_valid(rv_b), .rd_data(rd_b), .rom_addr(ra_b),
    .rom_data(rom_b2), .busy(busy_b)
  );

  // Texture contents: addr 2 and 12 are the glyph texels the routing tests use.
  function automatic logic [DW-1:0] tex(input logic [AW-1:0] a);
    case (a)
      5'd2:    return 4'b1000;
      5'd12:   return 4'b1111;
      default: return DW'((int'(a) * 7 + 3) % 16);
    endcase
  endfunction

  // ROM models: registered data_out, LA and LB clocks after the address.
  always @(posedge clk) begin
    rom_a  <= tex(ra_a);
    rom_b0 <= tex(ra_b);
    rom_b1 <= rom_b0;
    rom_b2 <= rom_b1;
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  int m_owner;   // -1: nobody owns the port
  int m_burst;
  int m_ptr;

  int            hist_w  [MAXC];  // winner per cycle, -1 if none
  logic [AW-1:0] hist_ad [MAXC];

  logic [N-1:0]  lg_g   [MAXC];
  logic [N-1:0]  lg_rva [MAXC];
  logic [N-1:0]  lg_rvb [MAXC];
  logic [DW-1:0] lg_rda [MAXC];
  logic          lg_ba  [MAXC];
  logic          lg_bb  [MAXC];

  int wait_c [N];
  bit counting = 1'b0;
  int n_g   = 0;
  int n_rva = 0;
  int n_rvb = 0;

  int exp_seq [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
  int c0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int first_from(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i);
    return addr_in[i*AW +: AW];
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr_in[i*AW +: AW] = a;
  endtask

  // Expected read return and busy for a port with read latency lat.
  task automatic exp_read(input int lat, output logic [N-1:0] rv,
                          output logic [DW-1:0] rd, output logic bsy);
    int src;
    src = cyc - 1 - lat;
    rv  = '0;
    rd  = '0;
    bsy = (m_owner >= 0);
    if (src >= 0 && hist_w[src] >= 0) begin
      rv = onehot(hist_w[src]);
      rd = tex(hist_ad[src]);
    end
    for (int k = 1; k <= lat + 1; k++) begin
      if (cyc - k >= 0 && hist_w[cyc - k] >= 0) bsy = 1'b1;
    end
  endtask

  // One clock cycle: sample at the falling edge, compare, advance the model.
  task automatic step();
    logic [N-1:0]  oth, eg, erv_a, erv_b;
    logic [DW-1:0] erd_a, erd_b;
    logic          eb_a, eb_b;
    int            w;
    @(negedge clk);
    w     = -1;
    erv_a = '0; erv_b = '0; erd_a = '0; erd_b = '0; eb_a = 1'b0; eb_b = 1'b0;
    if (!rst_n) begin
      m_owner = -1;
      m_burst = 0;
      m_ptr   = 0;
      for (int k = 1; k <= 6; k++) begin
        if (cyc - k >= 0) hist_w[cyc - k] = -1;
      end
      for (int i = 0; i < N; i++) wait_c[i] = 0;
    end else begin
      exp_read(LA, erv_a, erd_a, eb_a);
      exp_read(LB, erv_b, erd_b, eb_b);
      if (m_owner < 0) begin
        w = first_from(req, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_burst = 1;
        end
      end else begin
        oth          = req;
        oth[m_owner] = 1'b0;
        if (req[m_owner] && (m_burst < MB || oth == '0)) begin
          w = m_owner;
          if (m_burst < MB) m_burst++;
        end else begin
          w = first_from(oth, (m_owner + 1) % N);
          if (w >= 0) begin
            m_owner = w;
            m_burst = 1;
            m_ptr   = (w + 1) % N;
          end else begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
          end
        end
      end
    end
    eg          = onehot(w);
    hist_w[cyc]  = w;
    hist_ad[cyc] = (w >= 0) ? addr_of(w) : '0;

    check("gnt_a",  gnt_a,  eg);
    check("gnt_b",  gnt_b,  eg);
    check("rv_a",   rv_a,   erv_a);
    check("rd_a",   rd_a,   erd_a);
    check("busy_a", busy_a, eb_a);
    check("rv_b",   rv_b,   erv_b);
    check("rd_b",   rd_b,   erd_b);
    check("busy_b", busy_b, eb_b);
    check("gnt_onehot", $countones(gnt_a) <= 1, 1);

    for (int i = 0; i < N; i++) begin
      if (rst_n && req[i] && !gnt_a[i]) begin
        wait_c[i]++;
      end else begin
        if (counting && gnt_a[i]) check("starve", wait_c[i] > STARVE_MAX, 0);
        wait_c[i] = 0;
      end
    end
    if (counting) begin
      n_g   += $countones(gnt_a);
      n_rva += $countones(rv_a);
      n_rvb += $countones(rv_b);
    end

    lg_g[cyc]   = gnt_a;
    lg_rva[cyc] = rv_a;
    lg_rvb[cyc] = rv_b;
    lg_rda[cyc] = rd_a;
    lg_ba[cyc]  = busy_a;
    lg_bb[cyc]  = busy_b;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    foreach (hist_w[k]) hist_w[k] = -1;
    foreach (wait_c[i]) wait_c[i] = 0;
    m_owner = -1; m_burst = 0; m_ptr = 0;
    req     = '0;
    addr_in = '0;
    rst_n   = 1'b0;
    repeat (2) step();
    check("rst_gnt",  lg_g[1],   '0);
    check("rst_rv",   lg_rva[1], '0);
    check("rst_busy", lg_ba[1],  1'b0);
    rst_n = 1'b1;

    // Contention from IDLE: bursts of MAX_BURST rotating 0,1,2.
    c0  = cyc;
    req = '1;
    repeat (13) step();
    for (int k = 0; k < 13; k++) check("t3_seq", lg_g[c0 + k], onehot(exp_seq[k]));

    // Reset mid-burst with reads in flight.
    c0    = cyc;
    rst_n = 1'b0;
    repeat (2) step();
    for (int k = 0; k < 2; k++) begin
      check("t1_gnt",  lg_g[c0 + k],   '0);
      check("t1_rv_a", lg_rva[c0 + k], '0);
      check("t1_rv_b", lg_rvb[c0 + k], '0);
      check("t1_rd",   lg_rda[c0 + k], '0);
      check("t1_busy", lg_bb[c0 + k],  1'b0);
    end
    req   = '0;
    rst_n = 1'b1;
    c0    = cyc;
    repeat (5) step();
    for (int k = 0; k < 5; k++) begin
      check("t1_post_a", lg_rva[c0 + k], '0);
      check("t1_post_b", lg_rvb[c0 + k], '0);
    end

    // Single requester held: granted every cycle, never handed over.
    set_addr(1, 5'd12);
    req = 3'b010;
    c0  = cyc;
    repeat (8) step();
    for (int k = 0; k < 8; k++) check("t2_gnt", lg_g[c0 + k], 3'b010);
    for (int k = 2; k < 8; k++) begin
      check("t2_rv",   lg_rva[c0 + k], 3'b010);
      check("t2_data", lg_rda[c0 + k], 4'b1111);
    end
    for (int k = 4; k < 8; k++) check("t2_rv_b", lg_rvb[c0 + k], 3'b010);
    req = '0;
    repeat (6) step();

    // Early release: requester 0 drops after two grants, 2 takes over at once.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req   = 3'b101;
    c0    = cyc;
    repeat (2) step();
    req = 3'b100;
    repeat (2) step();
    check("t4_g0", lg_g[c0],     3'b001);
    check("t4_g1", lg_g[c0 + 1], 3'b001);
    check("t4_g2", lg_g[c0 + 2], 3'b100);
    check("t4_g3", lg_g[c0 + 3], 3'b100);

    // Routing: interleaved requesters 0 (addr 2) and 1 (addr 12).
    set_addr(0, 5'd2);
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      req = (k % 2 == 0) ? 3'b001 : 3'b010;
      step();
    end
    req = '0;
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      check("t5_rv",   lg_rva[c0 + 2 + k], (k % 2 == 0) ? 3'b001 : 3'b010);
      check("t5_data", lg_rda[c0 + 2 + k], (k % 2 == 0) ? 4'b1000 : 4'b1111);
    end

    // ROM_LAT=3: one grant in cycle C returns only in cycle C+4.
    repeat (4) step();
    c0  = cyc;
    req = 3'b001;
    step();
    req = '0;
    repeat (6) step();
    check("t6_gnt", lg_g[c0], 3'b001);
    for (int k = 1; k <= 6; k++) check("t6_rv_b", lg_rvb[c0 + k], (k == 4) ? 3'b001 : 3'b000);

    // Random stress: requests held until granted, occasionally withdrawn.
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    counting = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !lg_g[cyc - 1][i] && $urandom_range(0, 63) != 0) begin
          req[i] = 1'b1;
        end else begin
          req[i] = ($urandom_range(0, 99) < 55);
          if (req[i]) set_addr(i, AW'($urandom_range(0, 24)));
        end
      end
      step();
    end
    req = '0;
    repeat (8) step();
    counting = 1'b0;
    check("count_a", n_rva, n_g);
    check("count_b", n_rvb, n_g);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
